// File: rtl/cache_arbiter_pkg.sv
// Shared types and default widths for the L1 I/D-cache to physical-memory arbiter.
package cache_arbiter_pkg;

    localparam int unsigned CA_LINE_W   = 256;
    localparam int unsigned CA_ADDR_W   = 32;
    localparam int unsigned CA_OFFSET_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_BUSY = 3'd1,
        ST_D_BUSY = 3'd2,
        ST_I_DONE = 3'd3,
        ST_D_DONE = 3'd4
    } arb_state_t;

    typedef enum logic {
        ARB_I = 1'b0,
        ARB_D = 1'b1
    } arb_port_t;

    // Round-robin tie-break: the port that did not win last time.
    function automatic arb_port_t arb_other(input arb_port_t p);
        return (p == ARB_I) ? ARB_D : ARB_I;
    endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter multiplexing I-cache and D-cache line transactions onto one memory port.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int unsigned LINE_W   = CA_LINE_W,
    parameter int unsigned ADDR_W   = CA_ADDR_W,
    parameter int unsigned OFFSET_W = CA_OFFSET_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((ADDR_W'(1) << OFFSET_W) - ADDR_W'(1));

    arb_state_t        r_state;
    arb_port_t         r_last_grant;
    logic              r_pmem_read;
    logic              r_pmem_write;
    logic [ADDR_W-1:0] r_pmem_address;
    logic [LINE_W-1:0] r_pmem_wdata;
    logic [LINE_W-1:0] r_i_rdata;
    logic [LINE_W-1:0] r_d_rdata;
    logic              r_i_resp;
    logic              r_d_resp;

    arb_state_t        w_state_next;
    logic              w_grant_valid;
    arb_port_t         w_grant_port;
    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant_write;
    logic [ADDR_W-1:0] w_grant_addr;
    logic              w_busy_done;

    assign w_i_req       = i_read;
    assign w_d_req       = d_read | d_write;
    assign w_grant_write = (w_grant_port == ARB_D) && d_write;
    assign w_grant_addr  = ((w_grant_port == ARB_I) ? i_address : d_address) & ALIGN_MASK;
    assign w_busy_done   = pmem_resp && ((r_state == ST_I_BUSY) || (r_state == ST_D_BUSY));

    // Next-state and grant selection.
    always_comb begin
        w_state_next  = r_state;
        w_grant_valid = 1'b0;
        w_grant_port  = ARB_I;
        case (r_state)
            ST_IDLE: begin
                if (w_i_req && w_d_req) begin
                    w_grant_valid = 1'b1;
                    w_grant_port  = arb_other(r_last_grant);
                end else if (w_i_req) begin
                    w_grant_valid = 1'b1;
                    w_grant_port  = ARB_I;
                end else if (w_d_req) begin
                    w_grant_valid = 1'b1;
                    w_grant_port  = ARB_D;
                end
                if (w_grant_valid) begin
                    w_state_next = (w_grant_port == ARB_I) ? ST_I_BUSY : ST_D_BUSY;
                end
            end
            ST_I_BUSY: if (pmem_resp) w_state_next = ST_I_DONE;
            ST_D_BUSY: if (pmem_resp) w_state_next = ST_D_DONE;
            // The DONE cycle absorbs the requester's still-high request line.
            ST_I_DONE, ST_D_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_last_grant   <= ARB_D;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
            r_i_rdata      <= '0;
            r_d_rdata      <= '0;
            r_i_resp       <= 1'b0;
            r_d_resp       <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_i_resp <= (w_state_next == ST_I_DONE);
            r_d_resp <= (w_state_next == ST_D_DONE);
            if (w_grant_valid) begin
                r_last_grant   <= w_grant_port;
                r_pmem_address <= w_grant_addr;
                r_pmem_wdata   <= d_wdata;
                r_pmem_read    <= ~w_grant_write;
                r_pmem_write   <= w_grant_write;
            end else if (w_busy_done) begin
                r_pmem_read  <= 1'b0;
                r_pmem_write <= 1'b0;
                if (r_state == ST_I_BUSY) begin
                    r_i_rdata <= pmem_rdata;
                end else begin
                    r_d_rdata <= pmem_rdata;
                end
            end
        end
    end

    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;
    assign i_rdata      = r_i_rdata;
    assign d_rdata      = r_d_rdata;
    assign i_resp       = r_i_resp;
    assign d_resp       = r_d_resp;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: memory responder, grant/response monitor, directed and random traffic.
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_read = 1'b0;
    logic [31:0]  i_address = '0;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [31:0]  d_address = '0;
    logic [255:0] d_wdata = '0;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    always #5 clk = ~clk;

    cache_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    typedef struct packed {
        logic         wr;
        logic [255:0] data;
    } dexp_t;

    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

    int checks = 0;
    int errors = 0;

    logic [255:0] mem     [logic [31:0]];
    logic [255:0] ref_mem [logic [31:0]];
    logic [255:0] exp_i_q [$];
    dexp_t        exp_d_q [$];
    int           glog    [$];

    // Reference view of the requesters and arbitration history.
    bit           last_d = 1'b1;
    bit           ci_valid = 1'b0, ci_served = 1'b0;
    logic [31:0]  ci_addr = '0;
    bit           cd_valid = 1'b0, cd_served = 1'b0, cd_write = 1'b0;
    logic [31:0]  cd_addr = '0;
    logic [255:0] cd_wdata = '0;

    int lat_fixed = 0;
    bit spur_req = 1'b0;

    task automatic chk(input string name, input bit ok, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] fill(input logic [31:0] a);
        return {a, ~a, a ^ 32'h1357_9BDF, a + 32'd7, {a[15:0], a[31:16]}, a ^ 32'hFFFF_0000,
                a - 32'd3, a ^ 32'hC0FF_EE00};
    endfunction

    function automatic logic [255:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return fill(a);
    endfunction

    function automatic logic [255:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return fill(a);
    endfunction

    function automatic logic [255:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Physical memory: serves each request after a latency, or pulses a stray resp on demand.
    initial begin : responder
        logic [31:0]  a;
        logic         w;
        logic [255:0] wd;
        int           n;
        forever begin
            @(posedge clk); #1;
            if (spur_req) begin
                spur_req   = 1'b0;
                pmem_rdata = rand_line();
                pmem_resp  = 1'b1;
                @(posedge clk); #1;
                pmem_resp  = 1'b0;
            end else if (rst && (pmem_read || pmem_write)) begin
                a  = pmem_address;
                w  = pmem_write;
                wd = pmem_wdata;
                n  = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(0, 5));
                repeat (n) begin @(posedge clk); #1; end
                pmem_rdata = w ? rand_line() : mem_rd(a);
                if (w) mem[a] = wd;
                pmem_resp = 1'b1;
                @(posedge clk); #1;
                pmem_resp  = 1'b0;
                pmem_rdata = rand_line();
            end
        end
    end

    // Monitor: checks each new memory transaction against the round-robin rule and each resp against the queues.
    initial begin : monitor
        bit pi_s = 0, pd_s = 0, prev_active = 0, prev_ir = 0, prev_dr = 0, active;
        int win;
        logic [31:0]  t_addr;
        bit           t_write;
        logic [255:0] t_wdata;
        logic [255:0] e;
        dexp_t        de;
        t_addr = '0; t_write = 0; t_wdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pi_s = 0; pd_s = 0; prev_active = 0; prev_ir = 0; prev_dr = 0;
                continue;
            end
            active = pmem_read | pmem_write;
            if (active && !prev_active) begin
                if (pi_s && pd_s) win = last_d ? 0 : 1;
                else if (pi_s)    win = 0;
                else if (pd_s)    win = 1;
                else              win = 2;
                chk("grant_had_request", win != 2, 256'(win), 256'd0);
                if (win == 0) begin
                    chk("grant_i_addr", pmem_address == ci_addr, 256'(pmem_address), 256'(ci_addr));
                    chk("grant_i_op", pmem_read && !pmem_write, {pmem_read, pmem_write}, 256'd2);
                    chk("grant_i_once", ci_valid && !ci_served, {ci_valid, ci_served}, 256'd2);
                    ci_served = 1'b1;
                    last_d    = 1'b0;
                    glog.push_back(0);
                end else if (win == 1) begin
                    chk("grant_d_addr", pmem_address == cd_addr, 256'(pmem_address), 256'(cd_addr));
                    chk("grant_d_op", pmem_write == cd_write && pmem_read == !cd_write,
                        {pmem_read, pmem_write}, {!cd_write, cd_write});
                    if (cd_write) chk("grant_d_wdata", pmem_wdata == cd_wdata, pmem_wdata, cd_wdata);
                    chk("grant_d_once", cd_valid && !cd_served, {cd_valid, cd_served}, 256'd2);
                    cd_served = 1'b1;
                    last_d    = 1'b1;
                    glog.push_back(1);
                end
                t_addr = pmem_address; t_write = pmem_write; t_wdata = pmem_wdata;
            end else if (active) begin
                chk("pmem_hold", pmem_address == t_addr && pmem_write == t_write && pmem_read == !t_write
                    && (!t_write || pmem_wdata == t_wdata), {pmem_read, pmem_write, pmem_address},
                    {!t_write, t_write, t_addr});
            end
            prev_active = active;
            if (i_resp) begin
                chk("i_resp_single", !prev_ir, 256'(prev_ir), 256'd0);
                if (exp_i_q.size() == 0) chk("i_resp_expected", 1'b0, 256'd1, 256'd0);
                else begin
                    e = exp_i_q.pop_front();
                    chk("i_rdata", i_rdata == e, i_rdata, e);
                end
            end
            if (d_resp) begin
                chk("d_resp_single", !prev_dr, 256'(prev_dr), 256'd0);
                if (exp_d_q.size() == 0) chk("d_resp_expected", 1'b0, 256'd1, 256'd0);
                else begin
                    de = exp_d_q.pop_front();
                    if (!de.wr) chk("d_rdata", d_rdata == de.data, d_rdata, de.data);
                end
            end
            prev_ir = i_resp;
            prev_dr = d_resp;
            pi_s = i_read;
            pd_s = d_read | d_write;
        end
    end

    // Requester tasks: called at posedge+1, return at posedge+1 after dropping the request.
    task automatic do_i(input logic [31:0] a);
        bit got = 0;
        exp_i_q.push_back(ref_rd(a & LINE_MASK));
        ci_addr = a & LINE_MASK; ci_valid = 1'b1; ci_served = 1'b0;
        i_address = a;
        i_read = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (i_resp) begin got = 1; break; end
            if (ci_served) i_address = $urandom;
        end
        chk("i_resp_timeout", got, 256'(got), 256'd1);
        @(posedge clk); #1;
        i_read = 1'b0;
        ci_valid = 1'b0;
    endtask

    task automatic do_d(input logic [31:0] a, input bit rd, input bit wr, input logic [255:0] wd);
        bit    got = 0;
        dexp_t de;
        de.wr   = wr;
        de.data = wr ? wd : ref_rd(a & LINE_MASK);
        if (wr) ref_mem[a & LINE_MASK] = wd;
        exp_d_q.push_back(de);
        cd_addr = a & LINE_MASK; cd_write = wr; cd_wdata = wd; cd_valid = 1'b1; cd_served = 1'b0;
        d_address = a; d_wdata = wd;
        d_read = rd; d_write = wr;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (d_resp) begin got = 1; break; end
            if (cd_served) begin d_address = $urandom; d_wdata = rand_line(); end
        end
        chk("d_resp_timeout", got, 256'(got), 256'd1);
        @(posedge clk); #1;
        d_read = 1'b0; d_write = 1'b0;
        cd_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b0;
        last_d = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_d_addr();
        return 32'h8000_0000 | (32'($urandom_range(0, 15)) << 5) | 32'($urandom_range(0, 31));
    endfunction

    initial begin : main
        bit seen;
        logic [255:0] wd;
        repeat (2) @(posedge clk); #1;
        chk("rst_pmem_read", pmem_read == 0, 256'(pmem_read), 256'd0);
        chk("rst_pmem_write", pmem_write == 0, 256'(pmem_write), 256'd0);
        chk("rst_pmem_address", pmem_address == 0, 256'(pmem_address), 256'd0);
        chk("rst_pmem_wdata", pmem_wdata == 0, pmem_wdata, 256'd0);
        chk("rst_resp", i_resp == 0 && d_resp == 0, {i_resp, d_resp}, 256'd0);
        chk("rst_rdata", i_rdata == 0 && d_rdata == 0, i_rdata | d_rdata, 256'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed I read with a 5-cycle memory latency.
        mem[32'h0000_1220] = {64{4'hA}};
        ref_mem[32'h0000_1220] = {64{4'hA}};
        lat_fixed = 5;
        fork
            do_i(32'h0000_1234);
            begin
                @(posedge clk); #1;
                chk("t1_pmem_read", pmem_read == 1, 256'(pmem_read), 256'd1);
                chk("t1_pmem_address", pmem_address == 32'h0000_1220, 256'(pmem_address), 256'h1220);
                repeat (5) @(posedge clk);
                #1 chk("t1_resp_not_early", i_resp == 0, 256'(i_resp), 256'd0);
                @(posedge clk); #1;
                chk("t1_i_resp", i_resp == 1 && d_resp == 0 && pmem_read == 0, {i_resp, d_resp, pmem_read}, 256'd4);
                chk("t1_i_rdata", i_rdata == {64{4'hA}}, i_rdata, {64{4'hA}});
                @(posedge clk); #1;
                chk("t1_resp_drop", i_resp == 0, 256'(i_resp), 256'd0);
            end
        join

        // Directed D write-back.
        lat_fixed = 3;
        fork
            do_d(32'h8000_0040, 1'b0, 1'b1, {64{4'h5}});
            begin
                @(posedge clk); #1;
                chk("t2_pmem_write", pmem_write == 1 && pmem_read == 0, {pmem_read, pmem_write}, 256'd1);
                chk("t2_pmem_wdata", pmem_wdata == {64{4'h5}}, pmem_wdata, {64{4'h5}});
                chk("t2_pmem_address", pmem_address == 32'h8000_0040, 256'(pmem_address), 256'h8000_0040);
            end
        join
        lat_fixed = 0;

        // Ties after reset go I first, then alternate.
        do_reset();
        glog.delete();
        fork
            do_i(32'($urandom_range(0, 65535)));
            do_d(rand_d_addr(), 1'b1, 1'b0, '0);
        join
        chk("tie1_order", glog.size() == 2 && glog[0] == 0 && glog[1] == 1, 256'(glog.size()), 256'd2);
        do_i(32'($urandom_range(0, 65535)));
        glog.delete();
        fork
            do_i(32'($urandom_range(0, 65535)));
            do_d(rand_d_addr(), 1'b1, 1'b0, '0);
        join
        chk("tie2_order", glog.size() == 2 && glog[0] == 1 && glog[1] == 0, 256'(glog.size()), 256'd2);

        // Reset in the middle of a D read aborts it without a response.
        lat_fixed = 8;
        cd_addr = 32'h8000_0100; cd_write = 1'b0; cd_valid = 1'b1; cd_served = 1'b0;
        d_address = 32'h8000_0100;
        d_read = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (pmem_read) begin seen = 1; break; end
        end
        chk("t4_started", seen, 256'(seen), 256'd1);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("t4_async_drop", pmem_read == 0 && pmem_write == 0, {pmem_read, pmem_write}, 256'd0);
        chk("t4_rst_regs", pmem_address == 0 && d_rdata == 0 && i_rdata == 0, 256'(pmem_address) | d_rdata, 256'd0);
        d_read = 1'b0;
        cd_valid = 1'b0;
        last_d = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (i_resp || d_resp || pmem_read || pmem_write) seen = 1;
        end
        chk("t4_no_resp_after_abort", !seen, 256'(seen), 256'd0);
        lat_fixed = 0;
        @(posedge clk); #1;
        do_i(32'($urandom_range(0, 65535)));
        chk("t4_recovered", exp_i_q.size() == 0, 256'(exp_i_q.size()), 256'd0);

        // Read and write together performs a write; read it back.
        wd = rand_line();
        fork
            do_d(32'h8000_01E4, 1'b1, 1'b1, wd);
            begin
                @(posedge clk); #1;
                chk("t5_write_wins", pmem_write == 1 && pmem_read == 0, {pmem_read, pmem_write}, 256'd1);
            end
        join
        do_d(32'h8000_01E0, 1'b1, 1'b0, '0);

        // Stray memory resp while idle is ignored.
        spur_req = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (i_resp || d_resp || pmem_read || pmem_write) seen = 1;
        end
        chk("t6_spurious_ignored", !seen, 256'(seen), 256'd0);
        @(posedge clk); #1;
        fork
            do_i(32'($urandom_range(0, 65535)));
            begin
                @(posedge clk); #1;
                chk("t6_idle_grant", pmem_read == 1, 256'(pmem_read), 256'd1);
            end
        join

        // Random concurrent traffic.
        fork
            for (int n = 0; n < 25; n++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                do_i(32'($urandom_range(0, 65535)));
            end
            for (int n = 0; n < 25; n++) begin
                int op;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                op = int'($urandom_range(0, 2));
                do_d(rand_d_addr(), op != 1, op != 0, rand_line());
            end
        join

        repeat (5) @(posedge clk);
        chk("queues_drained", exp_i_q.size() == 0 && exp_d_q.size() == 0,
            256'(exp_i_q.size() + exp_d_q.size()), 256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
